// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback with a memory-ready handshake.
// Optional illegal-opcode trap state enabled by defining MULTICYCLE_CTRL_TRAP_EN.
module multicycle_control #(
    parameter int unsigned USE_READY = 1,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned OP_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count
`ifdef MULTICYCLE_CTRL_TRAP_EN
    ,
    output logic             illegal_op
`endif
);

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'h05);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'h08);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'h0c);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2b);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_TRAP   = 4'd12
    } state_e;

    state_e           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             is_bne_q, is_bne_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FETCH;
            op_q     <= '0;
            is_bne_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            is_bne_q <= is_bne_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state and control decode; controls are held at 0 while rst is high.
    always_comb begin
        rdy        = (USE_READY != 0) ? mem_ready : 1'b1;
        state_d    = state_q;
        op_d       = op_q;
        is_bne_d   = is_bne_q;
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        instr_done = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = rdy;
                    pc_write  = rdy;
                    if (rdy) state_d = S_DECODE;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    op_d      = opcode;
                    is_bne_d  = (opcode == OP_BNE);
                    if (opcode == OP_RTYPE)                         state_d = S_EXEC;
                    else if (opcode == OP_LW || opcode == OP_SW)    state_d = S_MEMADR;
                    else if (opcode == OP_BEQ || opcode == OP_BNE)  state_d = S_BRANCH;
                    else if (opcode == OP_J)                        state_d = S_JUMP;
                    else if (opcode == OP_ADDI || opcode == OP_ANDI) state_d = S_IEXEC;
                    else begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
                        state_d = S_TRAP;
`else
                        state_d    = S_FETCH;
                        instr_done = 1'b1;
`endif
                    end
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    if (rdy) state_d = S_MEMWB;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    state_d    = S_FETCH;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (rdy) begin
                        state_d    = S_FETCH;
                        instr_done = 1'b1;
                    end
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    state_d   = S_RWB;
                end
                S_RWB: begin
                    reg_dst    = 1'b1;
                    reg_write  = 1'b1;
                    state_d    = S_FETCH;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = 2'b01;
                    pc_source  = 2'b01;
                    pc_write   = zero ^ is_bne_q;
                    state_d    = S_FETCH;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_source  = 2'b10;
                    pc_write   = 1'b1;
                    state_d    = S_FETCH;
                    instr_done = 1'b1;
                end
                S_IEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = (op_q == OP_ANDI) ? 2'b11 : 2'b00;
                    state_d   = S_IWB;
                end
                S_IWB: begin
                    reg_write  = 1'b1;
                    state_d    = S_FETCH;
                    instr_done = 1'b1;
                end
`ifdef MULTICYCLE_CTRL_TRAP_EN
                S_TRAP: state_d = S_TRAP;
`endif
                default: state_d = S_FETCH;
            endcase
        end
        cnt_d = instr_done ? cnt_q + CNT_W'(1) : cnt_q;
    end

    assign state       = state_q;
    assign instr_count = cnt_q;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    assign illegal_op  = (state_q == S_TRAP) && !rst;
`endif

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised multi-cycle MIPS control unit. It replaces the single-cycle opcode decoder with a Moore/Mealy FSM that sequences fetch, decode, execute, memory and writeback over several cycles.
- Drives the shared-memory multi-cycle datapath: PC, IR, ALU input muxes, register file and memory.
- Adds a memory ready handshake, latched branch polarity and a retired-instruction counter.

Parameters:
- USE_READY, 1, 1 = memory states wait on mem_ready; 0 = mem_ready is ignored and treated as 1.
- CNT_W, 32, width of the retired-instruction counter.
- OP_W, 6, opcode width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- opcode  in  OP_W  instruction[31:26] from the IR; valid from the DECODE cycle onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  PC load enable (branch condition already resolved).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load enable.
- reg_dst  out  1  write register select: 1 = rd, 0 = rt.
- mem_to_reg  out  1  writeback data select: 1 = MDR, 0 = ALUOut.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B select: 00 = B register, 01 = 4, 10 = sign-extended imm, 11 = imm<<2.
- alu_op  out  2  ALU op class: 00 = add, 01 = sub, 10 = funct, 11 = and.
- pc_source  out  2  PC mux select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- state  out  4  current state encoding, for debug.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- instr_count  out  CNT_W  retired-instruction counter.

Behaviour:
- Reset (async, rst=1):
  - state = FETCH (0).
  - op_q, is_bne_q and instr_count cleared.
  - Every control output is forced to 0 while rst is high.
  - The FETCH output decode applies from the first cycle after release.
- Output defaults:
  - All outputs are 0 unless listed for the state.
  - Outputs are decoded from the state register plus mem_ready/zero where noted.
- rdy = USE_READY ? mem_ready : 1.
- Single-cycle states advance unconditionally.
- FETCH(0):
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=rdy, pc_write=rdy.
  - Next state: DECODE when rdy, otherwise hold.
- DECODE(1):
  - alu_src_a=0, alu_src_b=11, alu_op=00.
  - Registers: op_q <= opcode, is_bne_q <= (opcode==5).
  - Dispatch on opcode:
    - 0x00 -> EXEC.
    - 0x23 or 0x2b -> MEMADR.
    - 0x04 or 0x05 -> BRANCH.
    - 0x02 -> JUMP.
    - 0x08 or 0x0c -> IEXEC.
    - anything else -> ILLEGAL handling (see Optional Feature).
- MEMADR(2): alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEMRD if op_q==0x23, else MEMWR.
- MEMRD(3): mem_read=1, iord=1. Next state MEMWB on rdy, otherwise hold.
- MEMWB(4): reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH; retires.
- MEMWR(5): mem_write=1, iord=1. Next state FETCH on rdy (retires), otherwise hold with mem_write held high.
- EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=10. Next state RWB.
- RWB(7): reg_dst=1, reg_write=1. Next state FETCH; retires.
- BRANCH(8):
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01.
  - pc_write = zero ^ is_bne_q.
  - Next state FETCH; retires whether taken or not.
- JUMP(9): pc_source=10, pc_write=1. Next state FETCH; retires.
- IEXEC(10): alu_src_a=1, alu_src_b=10, alu_op = (op_q==0x0c) ? 11 : 00. Next state IWB.
- IWB(11): reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH; retires.
- Retire:
  - instr_done=1 in the cycle the FSM takes the final transition to FETCH.
  - instr_count increments on the same clock edge and wraps modulo 2^CNT_W, with no saturation.
- Boundary conditions:
  - mem_ready stuck low: the FSM holds indefinitely in FETCH, MEMRD or MEMWR, strobes stay asserted and the counter is unchanged.
  - An opcode change after DECODE has no effect; later states use op_q.
  - rst asserted in any state returns the FSM to FETCH immediately. No partial retire; the counter clears.
- States 12..15 unreachable without the optional feature; if ever entered, next state is FETCH with all outputs 0.

Optional Feature:
- Macro: MULTICYCLE_CTRL_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE goes to TRAP(12). TRAP holds forever with all outputs 0 except state.
  - Adds output port illegal_op (1 bit), which is high in TRAP and cleared only by rst.
  - A trapped instruction never retires.
- Undefined:
  - An unknown opcode in DECODE goes straight to FETCH as a NOP and retires (instr_done pulse, count +1).
  - No illegal_op port.

Test Plan:
- Reset, USE_READY=1, mem_ready=1, opcode=0x00 -> state sequence 0,1,6,7,0. reg_dst=1 and reg_write=1 in state 7. instr_done pulses once; instr_count=1.
- lw (0x23) with mem_ready low for 3 cycles in MEMRD -> state sequence 0,1,2,3,3,3,3,4,0. mem_read=1 and iord=1 throughout MEMRD; count +1 only at MEMWB exit.
- beq (0x04) with zero=1 -> pc_write=1, pc_source=01 in BRANCH. bne (0x05) with zero=1 -> pc_write=0. Both retire.
- andi (0x0c) -> alu_op=11 in IEXEC; addi (0x08) -> alu_op=00. Flip opcode to 0x23 during IEXEC -> no effect on outputs.
- Assert rst mid-MEMWR -> state=0 asynchronously, mem_write=0 immediately, instr_count=0.
- Opcode 0x3f: with MULTICYCLE_CTRL_TRAP_EN, state stays 12 and illegal_op=1 until rst. Without it, DECODE->FETCH and instr_count +1.
